// File: rtl/arith_unit_digit_serial.sv
// Digit-serial A + f(B) + cin unit: one DIGIT-bit slice per clock, carry held in a register,
// valid/ready handshake on both sides, carry/signed-overflow/zero flags.
module arith_unit_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] fb_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [DIGIT-1:0] a_sl_s;
  logic [DIGIT-1:0] fb_sl_s;
  logic [DIGIT-1:0] sum_s;
  logic             c_out_s;
  logic             c_msb_s;
  logic             last_s;
  int               off_s;
  logic [WIDTH-1:0] d_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  // B operand select: 00 zero, 01 B, 10 ~B, 11 all-ones.
  function automatic logic [WIDTH-1:0] sel_operand(input logic [1:0] s, input logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] r;
    case (s)
      2'b00:   r = {WIDTH{1'b0}};
      2'b01:   r = bv;
      2'b10:   r = ~bv;
      2'b11:   r = {WIDTH{1'b1}};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign start_ready = (state_r == IDLE);
  assign res_valid   = (state_r == DONE);
  assign d           = d_r;
  assign cout        = cout_r;
  assign ovf         = ovf_r;
  assign zero        = zero_r;

  // Slice adder; carry into the slice MSB is recovered from sum ^ a ^ f(b) so DIGIT=1 needs no special case.
  always_comb begin
    off_s     = int'(cnt_r) * DIGIT;
    a_sl_s    = a_r[off_s +: DIGIT];
    fb_sl_s   = fb_r[off_s +: DIGIT];
    {c_out_s, sum_s} = {1'b0, a_sl_s} + {1'b0, fb_sl_s} + {{DIGIT{1'b0}}, carry_r};
    c_msb_s   = sum_s[DIGIT-1] ^ a_sl_s[DIGIT-1] ^ fb_sl_s[DIGIT-1];
    acc_nxt_s = acc_r;
    acc_nxt_s[off_s +: DIGIT] = sum_s;
    last_s    = (cnt_r == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) state_nxt_s = RUN;
        else             state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (res_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and result/flag registers (results load only entering DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      fb_r    <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_r     <= a;
            fb_r    <= sel_operand(sel, b);
            carry_r <= cin;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          acc_r   <= acc_nxt_s;
          carry_r <= c_out_s;
          if (last_s) begin
            cnt_r  <= {CW{1'b0}};
            d_r    <= acc_nxt_s;
            cout_r <= c_out_s;
            ovf_r  <= c_msb_s ^ c_out_s;
            zero_r <= (acc_nxt_s == {WIDTH{1'b0}});
          end else begin
            cnt_r  <= cnt_r + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit_digit_serial.sv
// Directed-vector bench for arith_unit_digit_serial: DIGIT=8 main instance plus DIGIT=1 and
// DIGIT=32 instances for the width sweep; all share operands, each has its own start_valid.
module tb_arith_unit_digit_serial;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  sel;
  logic        cin;
  logic        res_ready;
  logic        start_valid_s [3];
  logic        start_ready_s [3];
  logic        res_valid_s   [3];
  logic [31:0] d_s           [3];
  logic        cout_s        [3];
  logic        ovf_s         [3];
  logic        zero_s        [3];

  int n_cmp;
  int n_err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    arith_unit_digit_serial #(
      .WIDTH(32),
      .DIGIT(g == 0 ? 8 : (g == 1 ? 1 : 32))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_valid(start_valid_s[g]),
      .start_ready(start_ready_s[g]),
      .a          (a),
      .b          (b),
      .sel        (sel),
      .cin        (cin),
      .res_valid  (res_valid_s[g]),
      .res_ready  (res_ready),
      .d          (d_s[g]),
      .cout       (cout_s[g]),
      .ovf        (ovf_s[g]),
      .zero       (zero_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dig(input int u);
    return (u == 0) ? 8 : ((u == 1) ? 1 : 32);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 33-bit add; signed overflow when operands share a sign the sum does not.
  function automatic logic [34:0] ref_model(input logic [31:0] av, input logic [31:0] bv,
                                            input logic [1:0] s, input logic c);
    logic [31:0] fb;
    logic [32:0] sum;
    logic        o;
    case (s)
      2'b00:   fb = 32'h0000_0000;
      2'b01:   fb = bv;
      2'b10:   fb = ~bv;
      default: fb = 32'hFFFF_FFFF;
    endcase
    sum = {1'b0, av} + {1'b0, fb} + {32'd0, c};
    o   = (av[31] == fb[31]) && (sum[31] != av[31]);
    return {(sum[31:0] == 32'd0), o, sum[32], sum[31:0]};
  endfunction

  task automatic run_op(input int u, input logic [31:0] av, input logic [31:0] bv,
                        input logic [1:0] s, input logic c, input logic scr, input logic rel,
                        input logic [31:0] ed, input logic ec, input logic eo, input logic ez);
    int cyc;
    a = av; b = bv; sel = s; cin = c;
    start_valid_s[u] = 1'b1;
    check_eq("ready_idle", start_ready_s[u], 1);
    @(posedge clk); #1;
    start_valid_s[u] = 1'b0;
    if (scr) begin
      a = ~av; b = ~bv; sel = ~s; cin = ~c;
    end
    cyc = 0;
    while (!res_valid_s[u] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", cyc, 32 / dig(u));
    check_eq("d", d_s[u], ed);
    check_eq("cout", cout_s[u], ec);
    check_eq("ovf", ovf_s[u], eo);
    check_eq("zero", zero_s[u], ez);
    if (rel) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check_eq("valid_drop", res_valid_s[u], 0);
      check_eq("d_hold", d_s[u], ed);
    end
  endtask

  initial begin
    logic [34:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; a = 32'd0; b = 32'd0; sel = 2'b00; cin = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) start_valid_s[i] = 1'b0;
    #12;
    check_eq("rst_ready", start_ready_s[0], 1);
    check_eq("rst_valid", res_valid_s[0], 0);
    check_eq("rst_d", d_s[0], 0);
    check_eq("rst_flags", {cout_s[0], ovf_s[0], zero_s[0]}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, DIGIT=8.
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op(0, 32'h0000_0005, 32'h0000_0005, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op(0, 32'h0000_0003, 32'h0000_0005, 2'b10, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op(0, 32'h0000_0000, 32'h1234_5678, 2'b11, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op(0, 32'h0000_0001, 32'h1234_5678, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op(0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op(0, 32'h8000_0000, 32'h0000_0001, 2'b10, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure with operands scrambled during RUN.
    run_op(0, 32'h1234_5678, 32'h1111_1111, 2'b01, 1'b0, 1'b1, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a = 32'hAAAA_AAAA;
      start_valid_s[0] = (i == 3);
      @(posedge clk); #1;
      start_valid_s[0] = 1'b0;
      check_eq("bp_valid", res_valid_s[0], 1);
      check_eq("bp_d", d_s[0], 32'h2345_6789);
      check_eq("bp_ready", start_ready_s[0], 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bp_no_accept", {start_ready_s[0], res_valid_s[0]}, 2'b10);
    end
    check_eq("bp_d_after", d_s[0], 32'h2345_6789);

    // Reset during RUN slice 2.
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; sel = 2'b01; cin = 1'b1;
    start_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    start_valid_s[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_running", start_ready_s[0], 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", start_ready_s[0], 1);
    check_eq("mid_rst_valid", res_valid_s[0], 0);
    check_eq("mid_rst_d", d_s[0], 0);
    check_eq("mid_rst_flags", {cout_s[0], ovf_s[0], zero_s[0]}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_valid", res_valid_s[0], 0);
    run_op(0, 32'h0000_FFFF, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

    // Width sweep over all sel/cin with random operands, each DIGIT.
    for (int u = 0; u < 3; u++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 2; c++) begin
          ra = $urandom;
          rb = $urandom;
          m  = ref_model(ra, rb, 2'(s), 1'(c));
          run_op(u, ra, rb, 2'(s), 1'(c), 1'b1, 1'b1, m[31:0], m[32], m[33], m[34]);
        end
      end
      run_op(u, 32'h7FFF_FFFF, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_op(u, 32'h0000_0001, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
